// File: rtl/seed_entry.sv
// seed_entry: debounced three-button entry of an 8x8 seed board.
//
// Each raw button runs through a 2-flop synchronizer and a counter debouncer;
// a debounced 0->1 edge gives a single-cycle press event. Events drive a small
// FSM (idle/edit/commit) that edits an 8-row buffer and publishes it as seed.
//
// Ports:
//   clk          system clock, posedge
//   rst          synchronous active-high reset
//   sw[7:0]      row pattern to load (bit 7 = leftmost cell)
//   btn_load     raw button, writes sw into the cursor row
//   btn_next     raw button, advances the cursor row (wraps 7 -> 0)
//   btn_commit   raw button, publishes the edit buffer to seed
//   seed[63:0]   published board, row r at bits [63-8r : 56-8r]
//   seed_strobe  one-cycle pulse on the cycle seed is updated
//   row_idx[2:0] cursor row
//   led[7:0]     edit-buffer contents of the cursor row
//   editing      edit buffer differs from published seed
//
// Build option: define SEED_ENTRY_PRESET_EN to reset buffer and seed to a
// preset pattern instead of all zeros.
module seed_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sw,
  input  logic        btn_load,
  input  logic        btn_next,
  input  logic        btn_commit,
  output logic [63:0] seed,
  output logic        seed_strobe,
  output logic [2:0]  row_idx,
  output logic [7:0]  led,
  output logic        editing
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

`ifdef SEED_ENTRY_PRESET_EN
  localparam logic [63:0] ResetSeed = 64'h0412_6424_0034_3C28;
`else
  localparam logic [63:0] ResetSeed = 64'h0;
`endif

  typedef enum logic [1:0] {StIdle, StEdit, StCommit} state_e;

  // Button index: 0 = load, 1 = next, 2 = commit.
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      level_q, level_d;
  logic [2:0]      press_q, press_d;
  logic [CntW-1:0] cnt_q [3];
  logic [CntW-1:0] cnt_d [3];

  state_e      state_q, state_d;
  logic [2:0]  row_q, row_d;
  logic [63:0] buf_q, buf_d;
  logic [63:0] seed_q, seed_d;
  logic        strobe_q, strobe_d;

  assign btn_raw = {btn_commit, btn_next, btn_load};

  // Debounce: accept the synchronized level only after it has disagreed with
  // the current level for DEBOUNCE_CYCLES consecutive cycles; any agreement
  // clears the count.
  always_comb begin
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  // Event priority commit > load > next; everything is dropped in commit.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    buf_d    = buf_q;
    seed_d   = seed_q;
    strobe_d = 1'b0;
    case (state_q)
      StCommit: state_d = StIdle;
      StIdle, StEdit: begin
        if (press_q[2]) begin
          state_d  = StCommit;
          seed_d   = buf_q;
          strobe_d = 1'b1;
        end else if (press_q[0]) begin
          // Row r lives at bit offset 8*(7-r); for 3 bits 7-r == ~r.
          buf_d[{~row_q, 3'b000} +: 8] = sw;
          state_d = StEdit;
        end else if (press_q[1]) begin
          row_d   = row_q + 3'd1;
          state_d = StEdit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      state_q  <= StIdle;
      row_q    <= '0;
      buf_q    <= ResetSeed;
      seed_q   <= ResetSeed;
      strobe_q <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      level_q  <= level_d;
      press_q  <= press_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      state_q  <= state_d;
      row_q    <= row_d;
      buf_q    <= buf_d;
      seed_q   <= seed_d;
      strobe_q <= strobe_d;
    end
  end

  assign seed        = seed_q;
  assign seed_strobe = strobe_q;
  assign row_idx     = row_q;
  assign led         = buf_q[{~row_q, 3'b000} +: 8];
  assign editing     = (buf_q != seed_q);

endmodule

// File: tb/tb_seed_entry.sv
// Self-checking bench for seed_entry with DEBOUNCE_CYCLES = 4.
// A behavioural model (row arrays, sample-history windows) predicts every
// output each cycle; directed scenarios add explicit end-state checks.
module tb_seed_entry;

  localparam int unsigned DB = 4;
  localparam logic [31:0] Mask = (32'd1 << DB) - 32'd1;
  localparam int Hold = 8;

`ifdef SEED_ENTRY_PRESET_EN
  localparam logic [63:0] ResetSeed = 64'h0412_6424_0034_3C28;
  localparam logic [7:0]  ResetLed  = 8'h04;
`else
  localparam logic [63:0] ResetSeed = 64'h0;
  localparam logic [7:0]  ResetLed  = 8'h00;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sw = 8'h00;
  logic        btn_load = 1'b0;
  logic        btn_next = 1'b0;
  logic        btn_commit = 1'b0;
  logic [63:0] seed;
  logic        seed_strobe;
  logic [2:0]  row_idx;
  logic [7:0]  led;
  logic        editing;
  logic [76:0] dut_vec;

  int n_vec = 0;
  int n_err = 0;

  seed_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .btn_load    (btn_load),
    .btn_next    (btn_next),
    .btn_commit  (btn_commit),
    .seed        (seed),
    .seed_strobe (seed_strobe),
    .row_idx     (row_idx),
    .led         (led),
    .editing     (editing)
  );

  always #5 clk = ~clk;

  assign dut_vec = {seed, seed_strobe, row_idx, led, editing};

  // ---------------- reference model ----------------
  bit [7:0]    m_buf [8];
  bit [7:0]    m_seed [8];
  int          m_state;  // 0 idle, 1 edit, 2 commit
  int          m_row;
  bit          m_strobe;
  bit [2:0]    m_lvl;
  bit [2:0]    m_ev;     // events visible to the FSM at the next edge
  logic [31:0] raw_hist [3];
  logic [31:0] seen_hist [3];

  function automatic void model_reset();
    logic [63:0] rs;
    rs = ResetSeed;
    for (int r = 0; r < 8; r++) begin
      m_buf[r]  = rs[63-8*r -: 8];
      m_seed[r] = rs[63-8*r -: 8];
    end
    m_state  = 0;
    m_row    = 0;
    m_strobe = 0;
    m_lvl    = '0;
    m_ev     = '0;
    for (int b = 0; b < 3; b++) begin
      raw_hist[b]  = '0;
      seen_hist[b] = '0;
    end
  endfunction

  function automatic void model_step(input bit r, input bit [7:0] s, input bit l,
                                     input bit n, input bit c);
    bit [2:0] raw;
    bit [2:0] new_ev;
    bit       seen;
    raw = {c, n, l};
    if (r) begin
      model_reset();
    end else begin
      m_strobe = 0;
      if (m_state == 2) begin
        m_state = 0;
      end else if (m_ev[2]) begin
        m_state  = 2;
        m_seed   = m_buf;
        m_strobe = 1;
      end else if (m_ev[0]) begin
        m_buf[m_row] = s;
        m_state      = 1;
      end else if (m_ev[1]) begin
        m_row   = (m_row + 1) % 8;
        m_state = 1;
      end
      // Debouncer sees the raw level from two edges ago; the level flips once
      // the last DB seen samples all disagree with it.
      new_ev = '0;
      for (int b = 0; b < 3; b++) begin
        seen         = raw_hist[b][1];
        raw_hist[b]  = {raw_hist[b][30:0], raw[b]};
        seen_hist[b] = {seen_hist[b][30:0], seen};
        if ((seen_hist[b] & Mask) == (m_lvl[b] ? 32'h0 : Mask)) begin
          m_lvl[b]  = ~m_lvl[b];
          new_ev[b] = m_lvl[b];
        end
      end
      m_ev = new_ev;
    end
  endfunction

  function automatic logic [76:0] exp_vec();
    logic [63:0] s;
    bit ed;
    ed = 0;
    for (int r = 0; r < 8; r++) begin
      s[63-8*r -: 8] = m_seed[r];
      if (m_buf[r] != m_seed[r]) ed = 1;
    end
    return {s, m_strobe, 3'(m_row), m_buf[m_row], ed};
  endfunction

  task automatic tick(input bit r, input bit [7:0] s, input bit l, input bit n,
                      input bit c);
    rst = r; sw = s; btn_load = l; btn_next = n; btn_commit = c;
    @(posedge clk);
    model_step(r, s, l, n, c);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    tick(1, 8'h00, 0, 0, 0);
    tick(1, 8'h00, 0, 0, 0);
    n_vec++;
    if (dut_vec !== exp_vec()) begin
      n_err++; $display("FAIL reset_vec dut=%h model=%h", dut_vec, exp_vec());
    end
    n_vec++;
    if (seed !== ResetSeed || led !== ResetLed || row_idx !== 3'd0 ||
        seed_strobe !== 1'b0 || editing !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs seed=%h led=%h row=%0d strobe=%b editing=%b",
               seed, led, row_idx, seed_strobe, editing);
    end
  endtask

  task automatic test_load_clean();
    int strobes = 0;
    tick(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 22; i++) begin
      tick(0, 8'hA5, i < 10, 0, 0);
      strobes += int'(seed_strobe);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL load_cycle%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (led !== 8'hA5 || editing !== 1'b1 || seed !== ResetSeed || strobes != 0) begin
      n_err++;
      $display("FAIL load_final led=%h (want a5) editing=%b seed=%h strobes=%0d (want 0)",
               led, editing, seed, strobes);
    end
  endtask

  task automatic test_next();
    tick(1, 8'h00, 0, 0, 0);
    for (int p = 0; p < 8; p++) begin
      for (int c = 0; c < 2 * Hold; c++) begin
        tick(0, 8'h00, 0, c < Hold, 0);
        n_vec++;
        if (dut_vec !== exp_vec()) begin
          n_err++; $display("FAIL next_p%0d_c%0d dut=%h model=%h", p, c, dut_vec, exp_vec());
        end
      end
      n_vec++;
      if (row_idx !== 3'((p + 1) % 8)) begin
        n_err++; $display("FAIL next_row p%0d row=%0d want=%0d", p, row_idx, (p + 1) % 8);
      end
    end
  endtask

  task automatic test_commit();
    int strobes = 0;
    tick(1, 8'h00, 0, 0, 0);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 4 * Hold; c++) begin
        tick(0, 8'(r + 1), (c < Hold), (c >= 2 * Hold) && (c < 3 * Hold), 0);
        n_vec++;
        if (dut_vec !== exp_vec()) begin
          n_err++; $display("FAIL fill_r%0d_c%0d dut=%h model=%h", r, c, dut_vec, exp_vec());
        end
      end
    end
    for (int c = 0; c < 2 * Hold; c++) begin
      tick(0, 8'hEE, 0, 0, c < Hold);
      strobes += int'(seed_strobe);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL commit_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (seed !== 64'h0102_0304_0506_0708 || editing !== 1'b0 || strobes != 1 ||
        row_idx !== 3'd0) begin
      n_err++;
      $display("FAIL commit_final seed=%h editing=%b strobes=%0d row=%0d", seed, editing,
               strobes, row_idx);
    end
  endtask

  task automatic test_bounce();
    tick(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      tick(0, 8'hFF, (i < 20) && ((i % 4) < 2), 0, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL bounce_c%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (led !== ResetLed || editing !== 1'b0) begin
      n_err++; $display("FAIL bounce_final led=%h want=%h editing=%b", led, ResetLed, editing);
    end
  endtask

  task automatic test_simultaneous();
    int strobes = 0;
    tick(1, 8'h00, 0, 0, 0);
    for (int c = 0; c < 2 * Hold; c++) begin
      tick(0, 8'h5A, c < Hold, 0, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL simul_pre_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
      end
    end
    for (int c = 0; c < 2 * Hold; c++) begin
      tick(0, 8'hFF, c < Hold, 0, c < Hold);
      strobes += int'(seed_strobe);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL simul_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (seed[63:56] !== 8'h5A || led !== 8'h5A || editing !== 1'b0 || strobes != 1) begin
      n_err++;
      $display("FAIL simul_final seed_row0=%h led=%h (want 5a) editing=%b strobes=%0d",
               seed[63:56], led, editing, strobes);
    end
  endtask

  task automatic test_reset_mid_edit();
    int strobes = 0;
    tick(1, 8'h00, 0, 0, 0);
    for (int c = 0; c < 3 * Hold; c++) begin
      tick(0, (c < 2 * Hold) ? 8'h77 : 8'h99, (c < Hold), (c >= Hold) && (c < 2 * Hold), 0);
    end
    for (int c = 0; c < 3; c++) tick(0, 8'h11, 1, 0, 0);
    for (int c = 0; c < 2; c++) begin
      tick(1, 8'h11, 0, 0, 0);
      strobes += int'(seed_strobe);
    end
    for (int c = 0; c < 2 * Hold; c++) begin
      tick(0, 8'h22, 0, 0, 0);
      strobes += int'(seed_strobe);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL rstmid_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (row_idx !== 3'd0 || seed !== ResetSeed || led !== ResetLed || editing !== 1'b0 ||
        strobes != 0) begin
      n_err++;
      $display("FAIL rstmid_final row=%0d seed=%h led=%h editing=%b strobes=%0d", row_idx,
               seed, led, editing, strobes);
    end
  endtask

  task automatic test_held_reset();
    tick(1, 8'h3C, 1, 0, 0);
    tick(1, 8'h3C, 1, 0, 0);
    for (int c = 0; c < 20; c++) begin
      tick(0, 8'h3C, c < 12, 0, 0);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL held_c%0d dut=%h model=%h", c, dut_vec, exp_vec());
      end
    end
    n_vec++;
    if (led !== 8'h3C || editing !== 1'b1) begin
      n_err++; $display("FAIL held_final led=%h (want 3c) editing=%b", led, editing);
    end
  endtask

  task automatic test_random();
    bit l = 0, n = 0, c = 0, r;
    bit [7:0] s;
    tick(1, 8'h00, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) l = ~l;
      if ($urandom_range(5) == 0) n = ~n;
      if ($urandom_range(7) == 0) c = ~c;
      s = 8'($urandom);
      r = ($urandom_range(199) == 0);
      tick(r, s, l, n, c);
      n_vec++;
      if (dut_vec !== exp_vec()) begin
        n_err++; $display("FAIL random_c%0d dut=%h model=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_clean();
    test_next();
    test_commit();
    test_bounce();
    test_simultaneous();
    test_reset_mid_edit();
    test_held_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seed_entry.md
SEED_ENTRY -- requirements
Module: seed_entry

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1250000, meaning consecutive stable cycles required to accept a button level (10 ms at 125 MHz).
REQ-002 Port clk  input  1  system clock; all logic on posedge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port sw  input  8  row pattern to load; bit 7 is leftmost cell.
REQ-005 Port btn_load  input  1  raw button; press writes sw into current row.
REQ-006 Port btn_next  input  1  raw button; press advances row cursor.
REQ-007 Port btn_commit  input  1  raw button; press publishes edit buffer.
REQ-008 Port seed  output  64  published 8x8 board for the game core; row r occupies bits [63-8r : 56-8r].
REQ-009 Port seed_strobe  output  1  one-cycle pulse on the cycle seed changes.
REQ-010 Port row_idx  output  3  current cursor row.
REQ-011 Port led  output  8  edit-buffer contents of row row_idx.
REQ-012 Port editing  output  1  high while edit buffer differs from published seed.

Function
REQ-013 Each raw button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 A press event SHALL be a single-cycle pulse on the debounced 0->1 transition; holding a button SHALL yield exactly one event; release yields none.
REQ-015 Press event SHALL occur no earlier than DEBOUNCE_CYCLES and no later than DEBOUNCE_CYCLES+3 cycles after a clean raw rising edge.
REQ-016 FSM states IDLE, EDIT, COMMIT; IDLE->EDIT on load or next event; EDIT->COMMIT on commit event; COMMIT->IDLE unconditionally after one cycle; commit event in IDLE SHALL also enter COMMIT.
REQ-017 Load event SHALL write sw into edit-buffer row row_idx on the following cycle; other rows unchanged.
REQ-018 Next event SHALL increment row_idx modulo 8 (7 wraps to 0).
REQ-019 In COMMIT, seed SHALL take the edit-buffer value and seed_strobe SHALL be high for exactly that cycle; seed SHALL be otherwise stable.
REQ-020 Simultaneous events in one cycle: commit > load > next; lower-priority events in that cycle SHALL be dropped.
REQ-021 Events arriving while in COMMIT SHALL be dropped.
REQ-022 Load with a value equal to the existing row SHALL still enter EDIT; editing SHALL reflect actual buffer/seed inequality, combinationally.
REQ-023 led SHALL be combinational from edit buffer and row_idx, reflecting a load on the cycle after the event.

Reset
REQ-024 rst SHALL, on the next posedge, force FSM to IDLE, row_idx=0, seed_strobe=0, debounced levels and counters=0, synchronizers=0.
REQ-025 Without SEED_ENTRY_PRESET_EN, edit buffer and seed SHALL reset to 64'h0; editing=0, led=8'h00.
REQ-026 Reset mid-debounce or mid-EDIT SHALL discard pending edits and events; no seed_strobe SHALL be produced by reset.
REQ-027 A button held through reset release SHALL produce one press event after DEBOUNCE_CYCLES.

Configuration
REQ-028 Macro SEED_ENTRY_PRESET_EN: when defined, reset SHALL load both edit buffer and seed with 64'h0412_6424_0034_3C28 (led=8'h04 after reset); when undefined, REQ-025 applies. No other behaviour differs.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, sw=8'hA5, clean btn_load pulse held 10 cycles -> one event, led=8'hA5, editing=1, seed unchanged, no strobe.
REQ-030 Eight btn_next presses from row 0 -> row_idx 1..7 then 0; led tracks each row.
REQ-031 Load rows 0..7 with 8'h01..8'h08, press btn_commit -> single seed_strobe, seed=64'h0102_0304_0506_0708, editing=0.
REQ-032 btn_load toggling every 2 cycles for 20 cycles then low -> no event, buffer unchanged.
REQ-033 btn_commit and btn_load events same cycle -> commit only; sw not written; strobe once.
REQ-034 rst asserted mid-EDIT with loaded rows -> row_idx=0, buffer/seed = 0 (or preset with SEED_ENTRY_PRESET_EN), no strobe.
